// File: rtl/hier_lane_dispatcher.sv
// Round-robin fan-out of one valid/ready stream onto NUM_LANES sibling leaf lanes.
// Holds a single registered beat, skips disabled lanes, counts completed transfers.
module hier_lane_dispatcher #(
  parameter int unsigned NUM_LANES = 5,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [NUM_LANES-1:0] lane_en,
  output logic                 out_valid,
  output logic [NUM_LANES-1:0] out_lane,
  output logic [DATA_W-1:0]    out_data,
  input  logic [NUM_LANES-1:0] lane_ready,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int unsigned PTR_W = $clog2(NUM_LANES);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] cand_idx;
  int unsigned      cand;
  logic             found;
  logic             out_fire;
  logic             in_fire;

  assign out_fire = out_valid & (|(out_lane & lane_ready));
  assign in_ready = ~rst & (~out_valid | out_fire) & (lane_en != '0);
  assign in_fire  = in_valid & in_ready;

  // Circular scan from rr_ptr for the first enabled lane.
  always_comb begin
    sel      = rr_ptr;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_LANES) begin
        cand = cand - NUM_LANES;
      end
      cand_idx = PTR_W'(cand);
      if (!found && lane_en[cand_idx]) begin
        sel   = cand_idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
    end else begin
      if (out_fire) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (in_fire) begin
        out_data  <= in_data;
        out_lane  <= NUM_LANES'(1) << sel;
        out_valid <= 1'b1;
        rr_ptr    <= (sel == PTR_W'(NUM_LANES - 1)) ? '0 : sel + PTR_W'(1);
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_lane  <= '0;
      end
    end
  end

  // The held destination is one-hot exactly when a beat is present.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(out_lane));
      assert ((out_lane != '0) == out_valid);
    end
  end

endmodule

// File: tb/tb_hier_lane_dispatcher.sv
// Bench for hier_lane_dispatcher: directed scenarios plus random traffic,
// every cycle compared against a behavioural lane/queue model.
module tb_hier_lane_dispatcher;

  localparam int unsigned N = 5;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [N-1:0] lane_en;
  logic         out_valid;
  logic [N-1:0] out_lane;
  logic [7:0]   out_data;
  logic [N-1:0] lane_ready;
  logic [15:0]  beat_cnt;

  hier_lane_dispatcher #(.NUM_LANES(N), .DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .lane_en(lane_en), .out_valid(out_valid),
    .out_lane(out_lane), .out_data(out_data), .lane_ready(lane_ready),
    .beat_cnt(beat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference state: a held beat destined for lane index m_lane.
  bit          m_valid;
  int          m_lane;
  logic [7:0]  m_data;
  int          m_ptr;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] exp_lane();
    logic [N-1:0] v;
    v = '0;
    if (m_valid) v[m_lane] = 1'b1;
    return v;
  endfunction

  // One clock: drive inputs, check the combinational ready, advance model, check outputs.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                       input logic [N-1:0] en, input logic [N-1:0] rdy);
    bit ofire, ir, ifire;
    int s;
    rst = r; in_valid = v; in_data = d; lane_en = en; lane_ready = rdy;
    #1;
    ofire = m_valid && rdy[m_lane];
    ir    = !r && (!m_valid || ofire) && (en != 0);
    ifire = v && ir;
    chk("in_ready", 32'(in_ready), 32'(ir));
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 0; m_lane = 0; m_data = '0; m_ptr = 0; m_cnt = '0;
    end else begin
      if (ofire) m_cnt = m_cnt + 16'd1;
      if (ifire) begin
        s = -1;
        for (int i = 0; i < N; i++) begin
          if (s < 0 && en[(m_ptr + i) % N]) s = (m_ptr + i) % N;
        end
        m_data  = d;
        m_lane  = s;
        m_valid = 1;
        m_ptr   = (s + 1) % N;
      end else if (ofire) begin
        m_valid = 0;
      end
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_lane", 32'(out_lane), 32'(exp_lane()));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; lane_en = '0; lane_ready = '0;
    m_valid = 0; m_lane = 0; m_data = '0; m_ptr = 0; m_cnt = '0;

    // Full-rate stream over all lanes.
    cycle(1, 0, 8'h00, 5'b11111, 5'b11111);
    chk("reset_lane", 32'(out_lane), 32'h0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 8'(8'h10 + i), 5'b11111, 5'b11111);
    cycle(0, 0, 8'h00, 5'b11111, 5'b11111);
    chk("stream_cnt", 32'(beat_cnt), 32'd10);

    // Sparse enable: lanes 2 and 4 alternate.
    cycle(1, 0, 8'h00, 5'b10100, 5'b11111);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 8'(8'h20 + i), 5'b10100, 5'b11111);
      chk("sparse_lane", 32'(out_lane), (i % 2 == 0) ? 32'h04 : 32'h10);
    end
    cycle(0, 0, 8'h00, 5'b10100, 5'b11111);

    // Backpressure on lane 0 while the other lanes are ready.
    cycle(1, 0, 8'h00, 5'b11111, 5'b11111);
    cycle(0, 1, 8'hAA, 5'b11111, 5'b11111);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 8'hBB, 5'b11111, 5'b11110);
      chk("bp_hold_data", 32'(out_data), 32'hAA);
    end
    cycle(0, 0, 8'h00, 5'b11111, 5'b11111);
    chk("bp_cnt", 32'(beat_cnt), 32'd1);

    // Held beat on lane 3 survives its lane being disabled.
    cycle(1, 0, 8'h00, 5'b01000, 5'b11111);
    cycle(0, 1, 8'h33, 5'b01000, 5'b11111);
    for (int i = 0; i < 2; i++) cycle(0, 1, 8'h44, 5'b00001, 5'b10111);
    chk("en_change_lane", 32'(out_lane), 32'h08);
    cycle(0, 1, 8'h55, 5'b00001, 5'b01000);
    chk("en_change_next", 32'(out_lane), 32'h01);
    cycle(0, 0, 8'h00, 5'b00001, 5'b11111);

    // No lanes enabled: nothing accepted; then only lane 3.
    cycle(0, 1, 8'h66, 5'b00000, 5'b11111);
    cycle(0, 1, 8'h66, 5'b00000, 5'b11111);
    chk("no_en_valid", 32'(out_valid), 32'h0);
    cycle(0, 1, 8'h77, 5'b01000, 5'b11111);
    chk("lane3_only", 32'(out_lane), 32'h08);
    cycle(0, 0, 8'h00, 5'b01000, 5'b11111);

    // Reset discards a held beat on lane 2.
    cycle(1, 0, 8'h00, 5'b00100, 5'b11111);
    cycle(0, 1, 8'h88, 5'b00100, 5'b00000);
    cycle(0, 1, 8'h99, 5'b00100, 5'b00000);
    cycle(1, 1, 8'h99, 5'b11111, 5'b11111);
    chk("rst_drop_valid", 32'(out_valid), 32'h0);
    cycle(0, 1, 8'h9A, 5'b11111, 5'b11111);
    chk("post_rst_lane", 32'(out_lane), 32'h01);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] en;
      en = ($urandom_range(0, 7) == 0) ? 5'b00000 : N'($urandom);
      cycle(($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0, 1'($urandom), 8'($urandom),
            en, N'($urandom));
    end

    // Counter wrap after 65536 transfers.
    cycle(1, 0, 8'h00, 5'b11111, 5'b11111);
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++)
      cycle(0, 1, 8'(i), 5'b11111, 5'b11111);
    chk("cnt_ffff", 32'(beat_cnt), 32'hFFFF);
    cycle(0, 0, 8'h00, 5'b11111, 5'b11111);
    chk("cnt_wrap", 32'(beat_cnt), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
